// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver. Each bit is resolved by a
// 3-sample majority vote around mid-bit, with runtime parity mode, 1 or 2
// stop bits, break detection, and a one-entry valid/ready output register.
module uart_rx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx,
  input  logic [1:0]            i_parity_mode,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_overrun,
  output logic                  o_busy
);
  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PH_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_WIDTH + 1);
  localparam int MID   = OVERSAMPLE / 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t state, state_nxt;

  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic [1:0]            rx_sync;
  logic                  rx_s, rx_d, fall;
  logic [PH_W-1:0]       ph;
  logic                  ph_clr;
  logic                  s_a, s_b, maj, mid_evt;
  logic [BC_W-1:0]       bcnt;
  logic [1:0]            par_mode;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  perr_acc, ferr_acc, zero_acc;
  logic                  ferr_fin, brk_fin, last_data, last_stop, wait_done;
  logic                  start_det, frame_done;

  // Free-running oversample tick, one clock wide every DIV clocks
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                            div_cnt <= '0;
    else if (div_cnt == DIV_W'(DIV - 1))    div_cnt <= '0;
    else                                    div_cnt <= div_cnt + 1'b1;
  end
  assign tick = (div_cnt == DIV_W'(DIV - 1));

  // Two-flop synchroniser plus one delay stage for falling-edge detect;
  // all reset high so reset release never looks like a start edge
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_sync <= 2'b11;
      rx_d    <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], i_rx};
      rx_d    <= rx_s;
    end
  end
  assign rx_s = rx_sync[1];
  assign fall = rx_d & ~rx_s;

  // Tick phase within the current bit; in WAIT_IDLE it counts high ticks
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)     ph <= '0;
    else if (ph_clr) ph <= '0;
    else if (tick)   ph <= (ph == PH_W'(OVERSAMPLE - 1)) ? '0 : ph + 1'b1;
  end

  // Vote uses the two stored samples plus the live line at the third tick
  assign mid_evt   = tick && (ph == PH_W'(MID + 1));
  assign maj       = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign last_data = mid_evt && (bcnt == BC_W'(DATA_WIDTH - 1));
  assign last_stop = mid_evt && (bcnt == BC_W'(STOP_BITS - 1));
  assign wait_done = tick && (ph == PH_W'(OVERSAMPLE - 1)) && rx_s;
  assign ferr_fin  = ferr_acc | ~maj;
  // Break also needs the first stop bit low; fold it in if it is the bit being sampled now
  assign brk_fin   = (bcnt == '0) ? (zero_acc & ~maj) : zero_acc;

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; every in-frame transition happens at a mid-bit vote
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (fall)      state_nxt = START;
      START:     if (mid_evt)   state_nxt = maj ? IDLE : DATA;
      DATA:      if (last_data) state_nxt = (^par_mode) ? PARITY : STOP;
      PARITY:    if (mid_evt)   state_nxt = STOP;
      STOP:      if (last_stop) state_nxt = ferr_fin ? WAIT_IDLE : IDLE;
      WAIT_IDLE: if (wait_done) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // FSM outputs and control strobes
  always_comb begin
    o_busy     = (state != IDLE);
    start_det  = (state == IDLE) && fall;
    frame_done = (state == STOP) && last_stop;
    ph_clr     = start_det ||
                 ((state == WAIT_IDLE) && !rx_s) ||
                 (frame_done && ferr_fin);
  end

  // Sample capture, bit counting and per-frame accumulators
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      s_a      <= 1'b1;
      s_b      <= 1'b1;
      bcnt     <= '0;
      par_mode <= 2'b00;
      shreg    <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
      zero_acc <= 1'b0;
    end else begin
      if (tick && (ph == PH_W'(MID - 1))) s_a <= rx_s;
      if (tick && (ph == PH_W'(MID)))     s_b <= rx_s;
      if (state_nxt != state) bcnt <= '0;
      else if (mid_evt)       bcnt <= bcnt + 1'b1;
      // Parity mode is frozen for the whole frame at the start edge
      if (start_det) begin
        par_mode <= i_parity_mode;
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
        zero_acc <= 1'b1;
      end
      if (mid_evt) begin
        case (state)
          DATA: begin
            shreg    <= {maj, shreg[DATA_WIDTH-1:1]};
            zero_acc <= zero_acc & ~maj;
          end
          PARITY: begin
            // mode[1] set means odd: an even total of ones is the error
            perr_acc <= (^shreg) ^ maj ^ par_mode[1];
            zero_acc <= zero_acc & ~maj;
          end
          STOP: begin
            ferr_acc <= ferr_acc | ~maj;
            if (bcnt == '0) zero_acc <= zero_acc & ~maj;
          end
          default: ;
        endcase
      end
    end
  end

  // One-entry holding register with valid/ready handshake and overrun pulse
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (frame_done && (!o_valid || i_ready)) begin
        o_data       <= shreg;
        o_valid      <= 1'b1;
        o_parity_err <= perr_acc;
        o_frame_err  <= ferr_fin;
        o_break      <= brk_fin;
      end else if (frame_done) begin
        o_overrun <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid      <= 1'b0;
        o_parity_err <= 1'b0;
        o_frame_err  <= 1'b0;
        o_break      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: table-driven frames on an 8-bit/1-stop receiver plus
// hand sequences for break, glitch, backpressure, reset and a 7-bit/2-stop
// receiver. Baud is raised so one bit is 128 clocks (DIV = 8).
module tb_uart_rx_param;
  localparam int CLK  = 10_000_000;
  localparam int BAUD = 78125;
  localparam int BIT  = 128;

  logic clk = 1'b0;
  logic rst;
  logic rx_a, rx_b, rdy_a, rdy_b;
  logic [1:0] mode_a, mode_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic val_a, perr_a, ferr_a, brk_a, ovr_a, busy_a;
  logic val_b, perr_b, ferr_b, brk_b, ovr_b, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_WIDTH(8), .CLK_FREQ(CLK), .BAUD_RATE(BAUD),
                  .OVERSAMPLE(16), .STOP_BITS(1)) u_a (
    .i_clock(clk), .i_reset(rst), .i_rx(rx_a), .i_parity_mode(mode_a),
    .i_ready(rdy_a), .o_data(data_a), .o_valid(val_a), .o_parity_err(perr_a),
    .o_frame_err(ferr_a), .o_break(brk_a), .o_overrun(ovr_a), .o_busy(busy_a));

  uart_rx_param #(.DATA_WIDTH(7), .CLK_FREQ(CLK), .BAUD_RATE(BAUD),
                  .OVERSAMPLE(16), .STOP_BITS(2)) u_b (
    .i_clock(clk), .i_reset(rst), .i_rx(rx_b), .i_parity_mode(mode_b),
    .i_ready(rdy_b), .o_data(data_b), .o_valid(val_b), .o_parity_err(perr_b),
    .o_frame_err(ferr_b), .o_break(brk_b), .o_overrun(ovr_b), .o_busy(busy_b));

  // Monitors: count o_valid rises, record o_busy at each rise, count overrun cycles
  int rise_a = 0, rise_b = 0, novr_a = 0;
  logic bz_rise_a = 1'b0, bz_rise_b = 1'b0;
  logic pv_a = 1'b0, pv_b = 1'b0;
  always @(negedge clk) begin
    if (val_a && !pv_a) begin rise_a++; bz_rise_a = busy_a; end
    if (val_b && !pv_b) begin rise_b++; bz_rise_b = busy_b; end
    pv_a = val_a;
    pv_b = val_b;
    if (ovr_a) novr_a++;
  end

  typedef struct {
    logic [1:0] mode;
    logic [7:0] data;
    logic       has_par, par, stop;
    logic [7:0] e_data;
    logic       e_perr, e_ferr, e_brk, e_busy;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic line_bit(input bit which, input logic v);
    if (which) rx_b = v; else rx_a = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input bit which, input int nd, input logic [8:0] d,
                      input logic has_par, input logic p, input int ns,
                      input logic [1:0] stops);
    line_bit(which, 1'b0);
    for (int i = 0; i < nd; i++) line_bit(which, d[i]);
    if (has_par) line_bit(which, p);
    for (int i = 0; i < ns; i++) line_bit(which, stops[i]);
  endtask

  task automatic ack_a(input string nm);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    chk({nm, "_ack_valid"}, val_a, 0);
    chk({nm, "_ack_flags"}, {perr_a, ferr_a, brk_a}, 0);
  endtask

  task automatic ack_b(input string nm);
    rdy_b = 1'b1;
    @(negedge clk);
    rdy_b = 1'b0;
    chk({nm, "_ack_valid"}, val_b, 0);
  endtask

  initial begin
    int r0, o0;
    //            mode   data   par? p     stop   exp   perr  ferr  brk   busy
    vecs[0] = '{2'b10, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 8'h82, 1'b1, 1'b0, 1'b1, 8'h82, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b00, 8'h82, 1'b0, 1'b0, 1'b1, 8'h82, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{2'b01, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b11, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{2'b01, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{2'b00, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    mode_a = 2'b00; mode_b = 2'b00;
    repeat (4) @(negedge clk);
    chk("rst_outs_a", {val_a, perr_a, ferr_a, brk_a, ovr_a, busy_a}, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_outs_b", {val_b, ferr_b, brk_b, busy_b}, 0);
    rst = 1'b0;
    line_bit(0, 1'b1);
    chk("idle_busy", busy_a, 0);

    // Table-driven frames, each held unacknowledged then acked
    foreach (vecs[k]) begin
      mode_a = vecs[k].mode;
      r0 = rise_a;
      send(0, 8, {1'b0, vecs[k].data}, vecs[k].has_par, vecs[k].par, 1, {1'b1, vecs[k].stop});
      line_bit(0, 1'b1);
      line_bit(0, 1'b1);
      chk($sformatf("v%0d_rise", k), rise_a, r0 + 1);
      chk($sformatf("v%0d_valid", k), val_a, 1);
      chk($sformatf("v%0d_data", k), data_a, vecs[k].e_data);
      chk($sformatf("v%0d_perr", k), perr_a, vecs[k].e_perr);
      chk($sformatf("v%0d_ferr", k), ferr_a, vecs[k].e_ferr);
      chk($sformatf("v%0d_brk", k), brk_a, vecs[k].e_brk);
      chk($sformatf("v%0d_busy_at_valid", k), bz_rise_a, vecs[k].e_busy);
      ack_a($sformatf("v%0d", k));
    end

    // Break: line low for two frame times, then release
    mode_a = 2'b00;
    r0 = rise_a;
    for (int i = 0; i < 20; i++) line_bit(0, 1'b0);
    chk("brk_rise", rise_a, r0 + 1);
    chk("brk_data", data_a, 0);
    chk("brk_flags", {brk_a, ferr_a, perr_a}, 3'b110);
    ack_a("brk");
    for (int i = 0; i < 3; i++) line_bit(0, 1'b0);
    chk("brk_hold_busy", busy_a, 1);
    chk("brk_no_second", rise_a, r0 + 1);
    rx_a = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    chk("brk_wait_half", busy_a, 1);
    line_bit(0, 1'b1);
    line_bit(0, 1'b1);
    chk("brk_back_idle", busy_a, 0);
    chk("brk_no_second2", rise_a, r0 + 1);

    // Glitch shorter than the first vote sample
    r0 = rise_a;
    rx_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_busy", busy_a, 1);
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (80) @(negedge clk);
    chk("glitch_idle", busy_a, 0);
    line_bit(0, 1'b1);
    chk("glitch_no_valid", rise_a, r0);

    // Backpressure: second back-to-back frame is dropped with a one-cycle overrun
    r0 = rise_a; o0 = novr_a;
    send(0, 8, 9'h003, 1'b0, 1'b0, 1, 2'b11);
    send(0, 8, 9'h082, 1'b0, 1'b0, 1, 2'b11);
    line_bit(0, 1'b1);
    chk("bp_rise", rise_a, r0 + 1);
    chk("bp_data", data_a, 8'h03);
    chk("bp_overrun_cycles", novr_a, o0 + 1);
    ack_a("bp");

    // Reset during data bit 4 of a frame while a word is still held
    send(0, 8, 9'h0FF, 1'b0, 1'b0, 1, 2'b11);
    line_bit(0, 1'b1);
    chk("prerst_valid", val_a, 1);
    line_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) line_bit(0, 1'b1);
    rx_a = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    chk("prerst_busy", busy_a, 1);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {val_a, perr_a, ferr_a, brk_a, ovr_a, busy_a}, 0);
    chk("midrst_data", data_a, 0);
    rx_a = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    line_bit(0, 1'b1);
    r0 = rise_a;
    send(0, 8, 9'h020, 1'b0, 1'b0, 1, 2'b11);
    line_bit(0, 1'b1);
    chk("postrst_rise", rise_a, r0 + 1);
    chk("postrst_data", data_a, 8'h20);
    chk("postrst_flags", {perr_a, ferr_a, brk_a}, 0);
    ack_a("postrst");

    // 7-bit, 2-stop receiver
    r0 = rise_b;
    send(1, 7, 9'h055, 1'b0, 1'b0, 2, 2'b01);
    line_bit(1, 1'b1);
    line_bit(1, 1'b1);
    chk("b55_rise", rise_b, r0 + 1);
    chk("b55_data", data_b, 7'h55);
    chk("b55_flags", {perr_b, ferr_b, brk_b}, 3'b010);
    chk("b55_busy_at_valid", bz_rise_b, 1);
    ack_b("b55");
    r0 = rise_b;
    send(1, 7, 9'h02A, 1'b0, 1'b0, 2, 2'b11);
    line_bit(1, 1'b1);
    chk("b2a_rise", rise_b, r0 + 1);
    chk("b2a_data", data_b, 7'h2A);
    chk("b2a_flags", {perr_b, ferr_b, brk_b}, 3'b000);
    chk("b2a_busy_at_valid", bz_rise_b, 0);
    ack_b("b2a");
    r0 = rise_b;
    send(1, 7, 9'h000, 1'b0, 1'b0, 2, 2'b10);
    line_bit(1, 1'b1);
    line_bit(1, 1'b1);
    chk("b00_rise", rise_b, r0 + 1);
    chk("b00_data", data_b, 7'h00);
    chk("b00_flags", {perr_b, ferr_b, brk_b}, 3'b011);
    ack_b("b00");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
